axi4lite_timer: RTL and testbench

- Memory-mapped timer peripheral on the core's external AXI4-Lite master port, directly downstream of the core-side AXI master in riscv_tcm_top.
- Decodes register reads and writes, runs a prescaled 32-bit up-counter with a compare match, and produces the level interrupt that drives the core's intr_i.
- It is the first slave on the external port.

---
 rtl/axi4lite_timer.sv | 188 ++++++++++++++++++
 tb/tb_axi4lite_timer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_timer.sv
// AXI4-Lite timer: prescaled 32-bit up-counter with compare match and a level interrupt.
// One write and one read may be outstanding at a time; AW and W are taken together.
module axi4lite_timer #(
  parameter int unsigned PRESCALE_W = 16,
  parameter logic [31:0] RESET_CMP  = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        axi_awvalid_i,
  input  logic [31:0] axi_awaddr_i,
  input  logic        axi_wvalid_i,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_bready_i,
  input  logic        axi_arvalid_i,
  input  logic [31:0] axi_araddr_i,
  input  logic        axi_rready_i,
  output logic        axi_awready_o,
  output logic        axi_wready_o,
  output logic        axi_bvalid_o,
  output logic [1:0]  axi_bresp_o,
  output logic        axi_arready_o,
  output logic        axi_rvalid_o,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic        intr_o
);

  localparam logic [2:0] AddrCtrl     = 3'd0;
  localparam logic [2:0] AddrStatus   = 3'd1;
  localparam logic [2:0] AddrCmp      = 3'd2;
  localparam logic [2:0] AddrCount    = 3'd3;
  localparam logic [2:0] AddrPrescale = 3'd4;
  localparam logic [1:0] RespOkay     = 2'b00;
  localparam logic [1:0] RespSlverr   = 2'b10;

  logic                  en_q, ie_q, reload_q, pend_q;
  logic                  en_d, ie_d, reload_d, pend_d;
  logic [31:0]           cmp_q, cmp_d, count_q, count_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q, wr_resp, rd_resp;
  logic [31:0]           rdata_q, rd_data;
  logic                  wr_accept, rd_accept, tick, match;
  logic [2:0]            wr_idx, rd_idx;
  logic                  unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  assign wr_idx      = axi_awaddr_i[4:2];
  assign rd_idx      = axi_araddr_i[4:2];
  assign unused_addr = ^{axi_awaddr_i[31:5], axi_awaddr_i[1:0],
                         axi_araddr_i[31:5], axi_araddr_i[1:0]};

  assign wr_accept = axi_awvalid_i & axi_wvalid_i & ~bvalid_q;
  assign rd_accept = axi_arvalid_i & ~rvalid_q;
  assign tick      = en_q & (pre_cnt_q == prescale_q);
  // Compare uses the pre-write COUNT so a same-cycle software write cannot mask a match.
  assign match     = tick & (count_q == cmp_q);
  assign wr_resp   = (wr_idx > AddrPrescale) ? RespSlverr : RespOkay;

  always_comb begin
    en_d       = en_q;
    ie_d       = ie_q;
    reload_d   = reload_q;
    pend_d     = pend_q;
    cmp_d      = cmp_q;
    count_d    = count_q;
    prescale_d = prescale_q;

    if (!en_q || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end

    if (tick) begin
      if (match) begin
        pend_d = 1'b1;
        if (reload_q) begin
          count_d = '0;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    // Software writes are applied last so they override the timer's own updates.
    if (wr_accept) begin
      case (wr_idx)
        AddrCtrl: begin
          if (axi_wstrb_i[0]) begin
            {reload_d, ie_d, en_d} = axi_wdata_i[2:0];
          end
        end
        AddrStatus: begin
          if (axi_wstrb_i[0] && axi_wdata_i[0] && !match) begin
            pend_d = 1'b0;
          end
        end
        AddrCmp:   cmp_d   = merge_bytes(cmp_q, axi_wdata_i, axi_wstrb_i);
        AddrCount: count_d = merge_bytes(count_d, axi_wdata_i, axi_wstrb_i);
        AddrPrescale: begin
          for (int i = 0; i < PRESCALE_W; i++) begin
            if (axi_wstrb_i[i/8]) begin
              prescale_d[i] = axi_wdata_i[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RespOkay;
    case (rd_idx)
      AddrCtrl:     rd_data = {29'd0, reload_q, ie_q, en_q};
      AddrStatus:   rd_data = {31'd0, pend_q};
      AddrCmp:      rd_data = cmp_q;
      AddrCount:    rd_data = count_q;
      AddrPrescale: rd_data = 32'(prescale_q);
      default:      rd_resp = RespSlverr;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      reload_q   <= 1'b0;
      pend_q     <= 1'b0;
      cmp_q      <= RESET_CMP;
      count_q    <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
    end else begin
      en_q       <= en_d;
      ie_q       <= ie_d;
      reload_q   <= reload_d;
      pend_q     <= pend_d;
      cmp_q      <= cmp_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      if (wr_accept) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (axi_bready_i) begin
        bvalid_q <= 1'b0;
      end
      if (rd_accept) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (axi_rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign axi_awready_o = wr_accept;
  assign axi_wready_o  = wr_accept;
  assign axi_bvalid_o  = bvalid_q;
  assign axi_bresp_o   = bresp_q;
  assign axi_arready_o = ~rvalid_q;
  assign axi_rvalid_o  = rvalid_q;
  assign axi_rdata_o   = rdata_q;
  assign axi_rresp_o   = rresp_q;
  assign intr_o        = pend_q & ie_q;

endmodule

// File: tb/tb_axi4lite_timer.sv
// Directed bench for axi4lite_timer: reset read-back table plus hand-timed sequences
// for prescaler period, one-shot, B back-pressure, W1C/match collision and wrap.
module tb_axi4lite_timer;

  localparam logic [31:0] ACtrl  = 32'h00;
  localparam logic [31:0] AStat  = 32'h04;
  localparam logic [31:0] ACmp   = 32'h08;
  localparam logic [31:0] ACount = 32'h0C;
  localparam logic [31:0] APre   = 32'h10;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, intr;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  rd_vec_t     rst_vecs [8];
  logic [31:0] d;
  logic [1:0]  r;
  int          a, acc, rise, ra, wa, seen, dacc, exp_rise;

  axi4lite_timer dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .axi_awvalid_i(awvalid),
    .axi_awaddr_i (awaddr),
    .axi_wvalid_i (wvalid),
    .axi_wdata_i  (wdata),
    .axi_wstrb_i  (wstrb),
    .axi_bready_i (bready),
    .axi_arvalid_i(arvalid),
    .axi_araddr_i (araddr),
    .axi_rready_i (rready),
    .axi_awready_o(awready),
    .axi_wready_o (wready),
    .axi_bvalid_o (bvalid),
    .axi_bresp_o  (bresp),
    .axi_arready_o(arready),
    .axi_rvalid_o (rvalid),
    .axi_rdata_o  (rdata),
    .axi_rresp_o  (rresp),
    .intr_o       (intr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Returns the cycle number of the accept edge in acc.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output int acc);
    int n = 0;
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data; wstrb = strb;
    #1;
    while (!awready && n < 50) begin @(negedge clk); #1; n++; end
    check("wr_awready", {31'd0, awready & wready}, 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    #1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); #1; n++; end
    check("wr_bvalid", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int acc);
    int n = 0;
    @(negedge clk);
    arvalid = 1'b1; araddr = addr;
    #1;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    check("rd_arready", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    #1;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); #1; n++; end
    check("rd_rvalid", {31'd0, rvalid}, 32'd1);
    data = rdata;
    resp = rresp;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wait_intr(output int at);
    int n = 0;
    while (!intr && n < 200) begin @(negedge clk); n++; end
    check("intr_rise_seen", {31'd0, intr}, 32'd1);
    at = cyc;
  endtask

  initial begin
    rst_vecs[0] = '{32'h00, 32'h0000_0000, 2'b00};
    rst_vecs[1] = '{32'h04, 32'h0000_0000, 2'b00};
    rst_vecs[2] = '{32'h08, 32'hFFFF_FFFF, 2'b00};
    rst_vecs[3] = '{32'h0C, 32'h0000_0000, 2'b00};
    rst_vecs[4] = '{32'h10, 32'h0000_0000, 2'b00};
    rst_vecs[5] = '{32'h14, 32'h0000_0000, 2'b10};
    rst_vecs[6] = '{32'h18, 32'h0000_0000, 2'b10};
    rst_vecs[7] = '{32'h1C, 32'h0000_0000, 2'b10};

    repeat (3) @(negedge clk);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_intr", {31'd0, intr}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      axi_read(rst_vecs[i].addr, d, r, a);
      check($sformatf("rst_rd_data_%0h", rst_vecs[i].addr), d, rst_vecs[i].data);
      check($sformatf("rst_rd_resp_%0h", rst_vecs[i].addr), {30'd0, r}, {30'd0, rst_vecs[i].resp});
    end

    // Auto-reload, prescale 0: match on the 6th tick, period 6.
    axi_write(ACmp, 32'd5, 4'hF, r, a);
    check("t1_bresp_okay", {30'd0, r}, 32'd0);
    axi_write(APre, 32'd0, 4'hF, r, a);
    axi_write(ACtrl, 32'h7, 4'hF, r, acc);
    wait_intr(rise);
    check("t1_first_match", rise - acc, 32'd6);
    axi_read(ACount, d, r, ra);
    check("t1_count_phase", d, (ra - 1 - acc) % 6);
    axi_read(AStat, d, r, a);
    check("t1_status_pend", d, 32'd1);
    axi_write(AStat, 32'd1, 4'h1, r, wa);
    exp_rise = acc + 6 * ((wa - acc) / 6 + 1);
    wait_intr(rise);
    check("t1_second_match", rise, exp_rise);

    // One-shot with prescale 3: match on the 3rd tick, 12 cycles after enable.
    axi_write(ACtrl, 32'h0, 4'hF, r, a);
    axi_write(AStat, 32'd1, 4'h1, r, a);
    axi_write(ACount, 32'd0, 4'hF, r, a);
    axi_write(APre, 32'd3, 4'hF, r, a);
    axi_write(ACmp, 32'd2, 4'hF, r, a);
    check("t2_intr_clear", {31'd0, intr}, 32'd0);
    axi_write(ACtrl, 32'h3, 4'hF, r, acc);
    wait_intr(rise);
    check("t2_oneshot_latency", rise - acc, 32'd12);
    axi_read(ACtrl, d, r, a);
    check("t2_ctrl_en_cleared", d, 32'h2);
    axi_read(ACount, d, r, a);
    check("t2_count_held", d, 32'd2);
    repeat (20) @(negedge clk);
    axi_read(ACount, d, r, a);
    check("t2_count_still_held", d, 32'd2);
    axi_read(APre, d, r, a);
    check("t2_prescale_rd", d, 32'd3);

    // B back-pressure: second write must wait until bvalid falls.
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = ACmp; wdata = 32'h1234; wstrb = 4'hF; bready = 1'b0;
    #1;
    check("t3_first_ready", {31'd0, awready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    wdata = 32'h5678;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t3_hold_bvalid_%0d", i), {31'd0, bvalid}, 32'd1);
      check($sformatf("t3_block_aw_%0d", i), {31'd0, awready}, 32'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    #1;
    check("t3_bvalid_fell", {31'd0, bvalid}, 32'd0);
    check("t3_second_ready", {31'd0, awready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    check("t3_second_bvalid", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    axi_read(ACmp, d, r, a);
    check("t3_cmp_second", d, 32'h5678);

    // STATUS W1C on the exact match edge: set wins.
    axi_write(ACtrl, 32'h0, 4'hF, r, a);
    axi_write(AStat, 32'd1, 4'h1, r, a);
    axi_write(APre, 32'd0, 4'hF, r, a);
    axi_write(ACmp, 32'd9, 4'hF, r, a);
    axi_write(ACount, 32'd0, 4'hF, r, a);
    axi_write(ACtrl, 32'h7, 4'hF, r, acc);
    seen = 0;
    while (cyc < acc + 9 && seen < 100) begin @(negedge clk); seen++; end
    awvalid = 1'b1; wvalid = 1'b1; awaddr = AStat; wdata = 32'd1; wstrb = 4'h1;
    #1;
    check("t4_w1c_ready", {31'd0, awready}, 32'd1);
    check("t4_pre_match", {31'd0, intr}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    check("t4_set_wins", {31'd0, intr}, 32'd1);
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    axi_write(ACtrl, 32'h0, 4'hF, r, a);
    check("t4_ie_mask", {31'd0, intr}, 32'd0);
    axi_read(AStat, d, r, a);
    check("t4_pend_kept", d, 32'd1);
    axi_write(AStat, 32'd1, 4'h1, r, a);
    axi_read(AStat, d, r, a);
    check("t4_w1c_clears", d, 32'd0);

    // Wrap past 0xFFFFFFFF with CMP=0x10: no interrupt.
    axi_write(ACmp, 32'h10, 4'hF, r, a);
    axi_write(ACount, 32'hFFFF_FFFF, 4'hF, r, a);
    axi_write(ACtrl, 32'h3, 4'hF, r, acc);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (intr) seen++;
    end
    check("t5_no_intr_on_wrap", seen, 32'd0);
    axi_write(ACtrl, 32'h0, 4'hF, r, dacc);
    axi_read(ACount, d, r, a);
    check("t5_count_wrapped", d, dacc - acc - 1);
    axi_read(AStat, d, r, a);
    check("t5_no_pend", d, 32'd0);

    // Byte-lane writes and unmapped write.
    axi_write(ACmp, 32'h1122_3344, 4'hF, r, a);
    axi_write(ACmp, 32'h0000_AB00, 4'b0010, r, a);
    axi_read(ACmp, d, r, a);
    check("t6_cmp_byte1", d, 32'h1122_AB44);
    axi_write(32'h18, 32'hFFFF_FFFF, 4'hF, r, a);
    check("t6_unmapped_bresp", {30'd0, r}, 32'h2);
    axi_read(ACtrl, d, r, a);
    check("t6_unmapped_no_effect", d, 32'h0);

    // Reset with a read response in flight drops it and restores CMP.
    @(negedge clk);
    arvalid = 1'b1; araddr = ACmp;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t7_rvalid_dropped", {31'd0, rvalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(ACmp, d, r, a);
    check("t7_cmp_reset", d, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
